// File: rtl/wb_merge_arbiter.sv
// wb_merge_arbiter
//   Merges the two writeback lanes of the dual-issue pipeline into one
//   program-ordered queue that drains into the single register-file write port.
//   Also provides a lookup of pending (not yet written) values for forwarding.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   wb0_valid/reg/data       lane 0 (older) writeback request
//   wb1_valid/reg/data       lane 1 (younger) writeback request
//   stall                    queue cannot accept two writes this cycle
//   rf_we/rf_waddr/rf_wdata  RF write port, driven from the queue head
//   q_reg, q_hit, q_data     pending-write lookup (youngest matching entry)
//   count                    occupied entries
//   overflow                 sticky flag: a write was lost to a full queue
module wb_merge_arbiter #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb0_valid,
   input  logic [REG_W-1:0]  wb0_reg,
   input  logic [DATA_W-1:0] wb0_data,
   input  logic              wb1_valid,
   input  logic [REG_W-1:0]  wb1_reg,
   input  logic [DATA_W-1:0] wb1_data,
   output logic              stall,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [REG_W-1:0]  q_reg,
   output logic              q_hit,
   output logic [DATA_W-1:0] q_data,
   output logic [CNT_W-1:0]  count,
   output logic              overflow
);

   logic [REG_W-1:0]  reg_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q, wr_ptr_nx;
   logic [CNT_W-1:0]  count_q, count_d, free;
   logic              overflow_q;

   logic              deq;
   logic              lane0_req, lane1_req;
   logic              first_vld, second_vld;
   logic [REG_W-1:0]  first_reg, second_reg;
   logic [DATA_W-1:0] first_data, second_data;
   logic              acc_first, acc_second, lost;
   logic [1:0]        n_acc;

   // Writes to reg 0 never occupy a slot. The surviving requests are packed
   // into "first" (older) and "second" (younger) so a lane 0 drop does not
   // leave a hole in the queue.
   always_comb begin
      lane0_req   = wb0_valid && (wb0_reg != '0);
      lane1_req   = wb1_valid && (wb1_reg != '0);
      first_vld   = 1'b0;
      first_reg   = '0;
      first_data  = '0;
      second_vld  = 1'b0;
      second_reg  = '0;
      second_data = '0;
      if (lane0_req) begin
         first_vld   = 1'b1;
         first_reg   = wb0_reg;
         first_data  = wb0_data;
         second_vld  = lane1_req;
         second_reg  = wb1_reg;
         second_data = wb1_data;
      end else if (lane1_req) begin
         first_vld   = 1'b1;
         first_reg   = wb1_reg;
         first_data  = wb1_data;
      end

      deq = (count_q != '0);
      // The head leaves on the same edge, so its slot is available to enqueue.
      free       = CNT_W'(DEPTH) - count_q + CNT_W'(deq);
      acc_first  = first_vld && (free != '0);
      acc_second = second_vld && (free >= CNT_W'(2));
      lost       = (first_vld && !acc_first) || (second_vld && !acc_second);
      n_acc      = {1'b0, acc_first} + {1'b0, acc_second};
      wr_ptr_nx  = wr_ptr_q + PTR_W'(1);
      count_d    = count_q - CNT_W'(deq) + CNT_W'(n_acc);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            reg_q[i]  <= '0;
            data_q[i] <= '0;
         end
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (acc_first) begin
            reg_q[wr_ptr_q]  <= first_reg;
            data_q[wr_ptr_q] <= first_data;
         end
         if (acc_second) begin
            reg_q[wr_ptr_nx]  <= second_reg;
            data_q[wr_ptr_nx] <= second_data;
         end
         rd_ptr_q <= rd_ptr_q + PTR_W'(deq);
         wr_ptr_q <= wr_ptr_q + PTR_W'(n_acc);
         count_q  <= count_d;
         if (lost) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // RF port is a pure function of registered state, so it only moves on clk.
   always_comb begin
      rf_we    = (count_q != '0);
      rf_waddr = rf_we ? reg_q[rd_ptr_q] : '0;
      rf_wdata = rf_we ? data_q[rd_ptr_q] : '0;
   end

   // Dequeue of this cycle is deliberately not credited here.
   assign stall    = (count_q > CNT_W'(DEPTH - 2));
   assign count    = count_q;
   assign overflow = overflow_q;

   // Walk from head (oldest) to tail; later matches override, leaving the youngest.
   always_comb begin
      logic [PTR_W-1:0] idx;
      q_hit  = 1'b0;
      q_data = '0;
      idx    = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (q_reg != '0) && (reg_q[idx] == q_reg)) begin
            q_hit  = 1'b1;
            q_data = data_q[idx];
         end
      end
   end

endmodule

// File: tb/tb_wb_merge_arbiter.sv
module tb_wb_merge_arbiter;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              wb0_valid = 1'b0, wb1_valid = 1'b0;
   logic [REG_W-1:0]  wb0_reg = '0, wb1_reg = '0, q_reg = '0;
   logic [DATA_W-1:0] wb0_data = '0, wb1_data = '0;
   logic              stall, rf_we, q_hit, overflow;
   logic [REG_W-1:0]  rf_waddr;
   logic [DATA_W-1:0] rf_wdata, q_data;
   logic [CNT_W-1:0]  count;

   wb_merge_arbiter #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W),
      .REG_W (REG_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb0_valid(wb0_valid),
      .wb0_reg  (wb0_reg),
      .wb0_data (wb0_data),
      .wb1_valid(wb1_valid),
      .wb1_reg  (wb1_reg),
      .wb1_data (wb1_data),
      .stall    (stall),
      .rf_we    (rf_we),
      .rf_waddr (rf_waddr),
      .rf_wdata (rf_wdata),
      .q_reg    (q_reg),
      .q_hit    (q_hit),
      .q_data   (q_data),
      .count    (count),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [REG_W-1:0]  r;
      logic [DATA_W-1:0] d;
   } ent_t;

   ent_t mq[$];    // pending writes, oldest first
   bit   ovf_m;
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      bit              hit_m;
      logic [DATA_W-1:0] qd_m;
      hit_m = 1'b0;
      qd_m  = '0;
      if (q_reg != 0) begin
         foreach (mq[i]) begin
            if (mq[i].r == q_reg) begin
               hit_m = 1'b1;
               qd_m  = mq[i].d;
            end
         end
      end
      check("count", 64'(count), 64'(mq.size()));
      check("stall", 64'(stall), 64'((int'(DEPTH) - mq.size()) < 2));
      check("rf_we", 64'(rf_we), 64'(mq.size() != 0));
      check("rf_waddr", 64'(rf_waddr), mq.size() != 0 ? 64'(mq[0].r) : 64'd0);
      check("rf_wdata", 64'(rf_wdata), mq.size() != 0 ? 64'(mq[0].d) : 64'd0);
      check("overflow", 64'(overflow), 64'(ovf_m));
      check("q_hit", 64'(q_hit), 64'(hit_m));
      check("q_data", 64'(q_data), 64'(qd_m));
   endtask

   task automatic model_push(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
      ent_t e;
      if (r == 0) return;
      if (mq.size() < int'(DEPTH)) begin
         e.r = r;
         e.d = d;
         mq.push_back(e);
      end else begin
         ovf_m = 1'b1;
      end
   endtask

   // Drive one cycle of inputs at negedge, check before the edge, then advance the model.
   task automatic step(input logic v0, input logic [REG_W-1:0] r0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [REG_W-1:0] r1, input logic [DATA_W-1:0] d1,
                       input logic [REG_W-1:0] q);
      ent_t tmp;
      @(negedge clk);
      wb0_valid = v0; wb0_reg = r0; wb0_data = d0;
      wb1_valid = v1; wb1_reg = r1; wb1_data = d1;
      q_reg = q;
      #1;
      check_all();
      @(posedge clk);
      if (mq.size() != 0) tmp = mq.pop_front();
      if (v0) model_push(r0, d0);
      if (v1) model_push(r1, d1);
   endtask

   task automatic idle(input logic [REG_W-1:0] q);
      step(1'b0, '0, '0, 1'b0, '0, '0, q);
   endtask

   initial begin
      ovf_m = 1'b0;
      // Reset state
      #2;
      check("rst_count", 64'(count), 64'd0);
      check("rst_we", 64'(rf_we), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // 1: single write latency
      step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 5'd3);
      idle(5'd3);
      check("t1_we", 64'(rf_we), 64'd1);
      check("t1_addr", 64'(rf_waddr), 64'd3);
      check("t1_data", 64'(rf_wdata), 64'h11);
      idle(5'd0);
      check("t1_empty", 64'(count), 64'd0);

      // 2: same-cycle writes to the same register
      step(1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB, 5'd5);
      idle(5'd5);
      check("t2_qdata", 64'(q_data), 64'hB);
      idle(5'd5);
      idle(5'd5);

      // 3: reg 0 is dropped
      step(1'b1, 5'd0, 32'hFF, 1'b1, 5'd7, 32'h1, 5'd0);
      idle(5'd0);
      check("t3_count", 64'(count), 64'd1);
      check("t3_addr", 64'(rf_waddr), 64'd7);
      idle(5'd0);

      // 4: fill past capacity; lane 0 kept over lane 1
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'(2 * i + 1), 32'(100 + 2 * i), 1'b1, 5'(2 * i + 2), 32'(101 + 2 * i), 5'd0);
      #1;
      check("t4_ovf", 64'(overflow), 64'd1);
      check("t4_stall", 64'(stall), 64'd1);
      for (int i = 0; i < 5; i++) idle(5'd0);

      // 5: lookup returns the youngest match
      step(1'b1, 5'd1, 32'h5, 1'b1, 5'd2, 32'h6, 5'd9);
      step(1'b1, 5'd9, 32'h1, 1'b1, 5'd9, 32'h2, 5'd9);
      step(1'b1, 5'd4, 32'h3, 1'b0, '0, '0, 5'd9);
      idle(5'd9);
      check("t5_hit", 64'(q_hit), 64'd1);
      check("t5_data", 64'(q_data), 64'h2);
      idle(5'd9);
      idle(5'd9);
      check("t5_nohit", 64'(q_hit), 64'd0);
      idle(5'd0);

      // 6: asynchronous reset with entries pending
      step(1'b1, 5'd1, 32'h21, 1'b1, 5'd2, 32'h22, 5'd0);
      step(1'b1, 5'd3, 32'h23, 1'b1, 5'd4, 32'h24, 5'd1);
      @(negedge clk);
      wb0_valid = 1'b0; wb1_valid = 1'b0; q_reg = 5'd3;
      #1;
      check("t6_pre", 64'(count), 64'd3);
      #1 rst = 1'b0;
      #1;
      check("t6_count", 64'(count), 64'd0);
      check("t6_we", 64'(rf_we), 64'd0);
      check("t6_addr", 64'(rf_waddr), 64'd0);
      check("t6_data", 64'(rf_wdata), 64'd0);
      check("t6_ovf", 64'(overflow), 64'd0);
      check("t6_hit", 64'(q_hit), 64'd0);
      mq.delete();
      ovf_m = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      idle(5'd0);
      idle(5'd0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)));
      end
      for (int i = 0; i < DEPTH + 1; i++) idle(5'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
